mem_xfer_ctrl: RTL and testbench

Sequencer for the memory-to-memory transfer datapath. It copies a block of 8-bit words from the source memory (memA, 8 words) into the 4-word target memory (memB). It can then optionally read both memories back and compare them word by word. It sits between the top-level start/done handshake and the two memories' address, write-enable and data pins. All memory traffic in a transfer is issued by this block.

---
 rtl/mem_xfer_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_xfer_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl: copies a block of words from memA into memB and can optionally
// read both back and compare them. All memory address and write-enable traffic originates here.
module mem_xfer_ctrl #(
  parameter int DW  = 8,
  parameter int AWA = 3,
  parameter int AWB = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [AWA-1:0] src_base,
  input  logic [AWB-1:0] dst_base,
  input  logic [AWB:0]   count,
  input  logic           verify,
  output logic [AWA-1:0] AddrA,
  input  logic [DW-1:0]  DOutA,
  output logic [AWB-1:0] AddrB,
  output logic           WEB,
  output logic [DW-1:0]  DataInB,
  input  logic [DW-1:0]  DOutB,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [AWB:0]   mismatch_cnt
);
  typedef enum logic [2:0] {IDLE, RD, WR, VRD, VCMP, DONE} stateT;

  function automatic logic [AWB:0] clampCount(input logic [AWB:0] req);
    logic [AWB:0] maxWords;
    maxWords = {1'b1, {AWB{1'b0}}};
    return (req > maxWords) ? maxWords : req;
  endfunction

  stateT          state, nextState;
  logic [AWB-1:0] idx, lastIdx, dstBase, addrBHold, dstAddr;
  logic [AWA-1:0] srcBase, addrAHold, srcAddr;
  logic [AWB:0]   nClamp, nMinus1;
  logic           verifyEn, lastWord, accept;

  assign nClamp   = clampCount(count);
  assign nMinus1  = nClamp - 1'b1;
  assign accept   = (state == IDLE) && start;
  assign lastWord = (idx == lastIdx);
  assign srcAddr  = srcBase + AWA'(idx);
  assign dstAddr  = dstBase + idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    AddrA     = addrAHold;
    AddrB     = addrBHold;
    WEB       = 1'b0;
    DataInB   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nextState = (nClamp == '0) ? DONE : RD;
      end
      RD: begin
        busy      = 1'b1;
        AddrA     = srcAddr;
        nextState = WR;
      end
      WR: begin
        busy    = 1'b1;
        WEB     = 1'b1;
        AddrB   = dstAddr;
        DataInB = DOutA;
        if (lastWord) nextState = verifyEn ? VRD : DONE;
        else          nextState = RD;
      end
      VRD: begin
        busy      = 1'b1;
        AddrA     = srcAddr;
        AddrB     = dstAddr;
        nextState = VCMP;
      end
      VCMP: begin
        busy      = 1'b1;
        nextState = lastWord ? DONE : VRD;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Control state: word index, held addresses, compare results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      verifyEn     <= 1'b0;
      addrAHold    <= '0;
      addrBHold    <= '0;
      error        <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      if (accept) begin
        idx          <= '0;
        verifyEn     <= verify;
        error        <= 1'b0;
        mismatch_cnt <= '0;
      end
      if (state == RD || state == VRD) addrAHold <= srcAddr;
      if (state == WR || state == VRD) addrBHold <= dstAddr;
      if (state == WR) idx <= lastWord ? '0 : idx + 1'b1;
      if (state == VCMP) begin
        if (DOutA != DOutB) begin
          error        <= 1'b1;
          mismatch_cnt <= mismatch_cnt + 1'b1;
        end
        if (!lastWord) idx <= idx + 1'b1;
      end
    end
  end

  // Transfer parameters captured at start; meaningful only while busy
  always_ff @(posedge clock) begin
    if (accept) begin
      srcBase <= src_base;
      dstBase <= dst_base;
      lastIdx <= nMinus1[AWB-1:0];
    end
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl: behavioural memA/memB around the sequencer, a table of
// directed transfers plus hand sequences for corruption, handshakes and mid-transfer reset.
module tb_mem_xfer_ctrl;
  logic       clock;
  logic       reset, start, verify, WEB, busy, done, error;
  logic [2:0] src_base, AddrA, count, mismatch_cnt;
  logic [1:0] dst_base, AddrB;
  logic [7:0] DOutA, DataInB, DOutB, dOutBReg;
  logic       forceB, clearReq;
  logic [7:0] memA [8];
  logic [7:0] memB [4];

  int nCompared = 0;
  int nMismatch = 0;

  mem_xfer_ctrl #(.DW(8), .AWA(3), .AWB(2)) dut (
    .clock(clock), .reset(reset), .start(start), .src_base(src_base),
    .dst_base(dst_base), .count(count), .verify(verify), .AddrA(AddrA),
    .DOutA(DOutA), .AddrB(AddrB), .WEB(WEB), .DataInB(DataInB), .DOutB(DOutB),
    .busy(busy), .done(done), .error(error), .mismatch_cnt(mismatch_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign DOutB = forceB ? 8'hFF : dOutBReg;

  always @(posedge clock) begin
    DOutA <= memA[AddrA];
    if (clearReq) begin
      for (int i = 0; i < 4; i++) memB[i] <= 8'hEE;
    end else if (WEB) begin
      memB[AddrB] <= DataInB;
    end else begin
      dOutBReg <= memB[AddrB];
    end
  end

  typedef struct {
    logic [2:0]  src;
    logic [1:0]  dst;
    logic [2:0]  cnt;
    logic        vfy;
    int          expDone;
    int          expWrites;
    logic [31:0] expB;
  } vecT;

  vecT vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clearB;
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
  endtask

  function automatic logic [31:0] memBWord();
    return {memB[3], memB[2], memB[1], memB[0]};
  endfunction

  task automatic runXfer(input logic [2:0] s, input logic [1:0] d, input logic [2:0] n,
                         input logic v, input int corruptCycle, input int pulseCycle,
                         output int doneCyc, output int writes, output int badCycles);
    doneCyc = 0; writes = 0; badCycles = 0;
    src_base = s; dst_base = d; count = n; verify = v; start = 1'b1;
    tick();
    for (int c = 1; c <= 60; c++) begin
      start = (c == pulseCycle);
      if (c == pulseCycle) begin
        src_base = 3'd4;
        count    = 3'd4;
      end
      forceB = (c == corruptCycle);
      if (WEB) begin
        writes++;
        if (c != 2 * writes) badCycles++;
      end else if (DataInB != 8'h00) begin
        badCycles++;
      end
      if (done) begin
        doneCyc = c;
        if (busy) badCycles++;
        break;
      end
      if (!busy) badCycles++;
      tick();
    end
    forceB = 1'b0;
    start  = 1'b0;
  endtask

  initial begin
    int dc, wr, bad, doneSeen, webSeen;
    memA[0] = 8'h11; memA[1] = 8'h22; memA[2] = 8'h33; memA[3] = 8'h44;
    memA[4] = 8'h55; memA[5] = 8'h66; memA[6] = 8'hA6; memA[7] = 8'hA7;
    vecs[0] = '{3'd0, 2'd0, 3'd4, 1'b0, 9,  4, {8'h44, 8'h33, 8'h22, 8'h11}};
    vecs[1] = '{3'd6, 2'd3, 3'd3, 1'b0, 7,  3, {8'hA6, 8'hEE, 8'h11, 8'hA7}};
    vecs[2] = '{3'd0, 2'd0, 3'd4, 1'b1, 17, 4, {8'h44, 8'h33, 8'h22, 8'h11}};
    vecs[3] = '{3'd5, 2'd1, 3'd0, 1'b1, 1,  0, {8'hEE, 8'hEE, 8'hEE, 8'hEE}};
    vecs[4] = '{3'd2, 2'd1, 3'd7, 1'b0, 9,  4, {8'h55, 8'h44, 8'h33, 8'h66}};
    vecs[5] = '{3'd7, 2'd2, 3'd1, 1'b1, 5,  1, {8'hEE, 8'hA7, 8'hEE, 8'hEE}};
    vecs[6] = '{3'd5, 2'd3, 3'd2, 1'b1, 9,  2, {8'h66, 8'hEE, 8'hEE, 8'hA6}};

    reset = 1'b1; start = 1'b0; verify = 1'b0; src_base = '0; dst_base = '0;
    count = '0; forceB = 1'b0; clearReq = 1'b0;
    #2;
    check("reset_outputs",
          32'({AddrA, AddrB, WEB, DataInB, busy, done, error, mismatch_cnt}), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      clearB();
      runXfer(vecs[i].src, vecs[i].dst, vecs[i].cnt, vecs[i].vfy, -1, -1, dc, wr, bad);
      check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(vecs[i].expDone));
      check($sformatf("v%0d_writes", i), 32'(wr), 32'(vecs[i].expWrites));
      check($sformatf("v%0d_bad_cycles", i), 32'(bad), 32'd0);
      check($sformatf("v%0d_error", i), 32'(error), 32'd0);
      check($sformatf("v%0d_mismatch_cnt", i), 32'(mismatch_cnt), 32'd0);
      check($sformatf("v%0d_memB", i), memBWord(), vecs[i].expB);
      tick();
      check($sformatf("v%0d_after_idle", i), 32'({busy, done}), 32'd0);
    end

    // Verify pass with word 2 read back as FF
    clearB();
    runXfer(3'd0, 2'd0, 3'd4, 1'b1, 14, -1, dc, wr, bad);
    check("corrupt_done_cycle", 32'(dc), 32'd17);
    check("corrupt_error", 32'(error), 32'd1);
    check("corrupt_mismatch_cnt", 32'(mismatch_cnt), 32'd1);
    repeat (3) tick();
    check("corrupt_error_sticky", 32'({error, mismatch_cnt}), 32'({1'b1, 3'd1}));
    runXfer(3'd0, 2'd0, 3'd0, 1'b0, -1, -1, dc, wr, bad);
    check("corrupt_cleared_by_start", 32'({error, mismatch_cnt}), 32'd0);
    tick();

    // start pulsed in a WR cycle is ignored
    clearB();
    runXfer(3'd0, 2'd0, 3'd2, 1'b0, -1, 2, dc, wr, bad);
    check("busy_start_done_cycle", 32'(dc), 32'd5);
    check("busy_start_writes", 32'(wr), 32'd2);
    check("busy_start_memB", memBWord(), {8'hEE, 8'hEE, 8'h22, 8'h11});
    tick();
    check("busy_start_not_queued", 32'({busy, done}), 32'd0);

    // start held across DONE restarts in the following IDLE cycle
    clearB();
    src_base = 3'd3; dst_base = 2'd0; count = 3'd1; verify = 1'b0; start = 1'b1;
    tick();
    tick();
    check("held_wr_cycle2", 32'({WEB, DataInB}), 32'({1'b1, 8'h44}));
    tick();
    check("held_done_cycle3", 32'(done), 32'd1);
    tick();
    check("held_idle_cycle4", 32'({busy, done}), 32'd0);
    tick();
    check("held_restart_cycle5", 32'({busy, AddrA}), 32'({1'b1, 3'd3}));
    start = 1'b0;
    tick();
    tick();
    check("held_done_cycle7", 32'(done), 32'd1);
    tick();
    check("held_memB0", 32'(memB[0]), 32'h44);

    // Reset asserted in word 2's WR cycle
    clearB();
    src_base = 3'd0; dst_base = 2'd0; count = 3'd4; verify = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("rst_pre_wr", 32'({WEB, DataInB}), 32'({1'b1, 8'h33}));
    reset = 1'b1;
    #1;
    check("rst_outputs",
          32'({AddrA, AddrB, WEB, DataInB, busy, done, error, mismatch_cnt}), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    doneSeen = 0; webSeen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) doneSeen++;
      if (WEB) webSeen++;
      tick();
    end
    check("rst_no_done", 32'(doneSeen), 32'd0);
    check("rst_no_writes", 32'(webSeen), 32'd0);
    check("rst_memB", memBWord(), {8'hEE, 8'hEE, 8'h22, 8'h11});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
